// File: rtl/spu_fetch_pkg.sv
// Shared types for the SPU fetch/decode boundary: instruction word, PC and buffered entry.
// Used by inst_pair_buffer (optional statistics under INST_PAIR_BUF_STATS_EN).
package spu_fetch_pkg;
    localparam int bitsize = 11;

    typedef logic [31:0]        inst_t;
    typedef logic [bitsize-1:0] pc_t;

    typedef struct packed {
        inst_t inst;
        pc_t   pc;
    } buf_entry_t;

    localparam inst_t NOP = 32'h4020_0000;

    // PC counts instruction words and wraps at the PC width
    function automatic pc_t pc_next(input pc_t pc);
        return pc + pc_t'(1);
    endfunction
endpackage

// File: rtl/inst_pair_buffer_if.sv
// Fetch-side and decode-side signals of the instruction pair buffer.
// master drives fetch/decode requests; slave is the buffer itself.
interface inst_pair_buffer_if;
    import spu_fetch_pkg::*;

    logic       fetch_valid;
    logic       fetch_ready;
    inst_t      fetch_inst1;
    inst_t      fetch_inst2;
    pc_t        fetch_pc;
    logic       flush;
    logic [1:0] issue_count;
    logic       out_valid1;
    logic       out_valid2;
    inst_t      out_inst1;
    inst_t      out_inst2;
    pc_t        out_pc1;
    pc_t        out_pc2;

    modport master (
        output fetch_valid, fetch_inst1, fetch_inst2, fetch_pc, flush, issue_count,
        input  fetch_ready, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2
    );

    modport slave (
        input  fetch_valid, fetch_inst1, fetch_inst2, fetch_pc, flush, issue_count,
        output fetch_ready, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2
    );
endinterface

// File: rtl/pair_buf_stats.sv
// Saturating occupancy statistics for inst_pair_buffer; only built under INST_PAIR_BUF_STATS_EN.
module pair_buf_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_stall,
    input  logic [1:0]  i_eff,
    output logic [15:0] o_full_stall_cnt,
    output logic [31:0] o_issue_word_cnt
);
    logic [15:0] r_stall;
    logic [31:0] r_words;
    logic [32:0] w_words_sum;

    assign w_words_sum = {1'b0, r_words} + 33'(i_eff);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
            r_words <= '0;
        end else if (i_clear) begin
            r_stall <= '0;
            r_words <= '0;
        end else begin
            if (i_stall && (r_stall != 16'hFFFF))
                r_stall <= r_stall + 16'd1;
            r_words <= w_words_sum[32] ? 32'hFFFF_FFFF : w_words_sum[31:0];
        end
    end

    assign o_full_stall_cnt = r_stall;
    assign o_issue_word_cnt = r_words;
endmodule

// File: rtl/inst_pair_buffer.sv
// Circular buffer between fetch (2 words/cycle in) and dual-issue decode (0..2 words/cycle out).
// Define INST_PAIR_BUF_STATS_EN to add full_stall_cnt / issue_word_cnt outputs.
module inst_pair_buffer
    import spu_fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    inst_pair_buffer_if.slave   bus
`ifdef INST_PAIR_BUF_STATS_EN
    ,
    output logic [15:0]         full_stall_cnt,
    output logic [31:0]         issue_word_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    buf_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_ready;
    logic          w_push;
    logic [1:0]    w_req;
    logic [1:0]    w_eff;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_wr_ptr2;
    logic [PW-1:0] w_rd_idx   [2];
    logic          w_lane_vld [2];
    buf_entry_t    w_lane_ent [2];

    // Ready looks only at the registered count, so it never depends on this cycle's issue/flush
    assign w_ready      = (r_count <= CW'(DEPTH - 2));
    assign w_push       = bus.fetch_valid && w_ready && !bus.flush;
    assign w_req        = (bus.issue_count == 2'd3) ? 2'd2 : bus.issue_count;
    assign w_eff        = (CW'(w_req) > r_count) ? r_count[1:0] : w_req;
    assign w_count_next = r_count + (w_push ? CW'(2) : CW'(0)) - CW'(w_eff);
    assign w_wr_ptr2    = r_wr_ptr + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PW'(w_eff);
            r_wr_ptr <= w_push ? r_wr_ptr + PW'(2) : r_wr_ptr;
            r_count  <= w_count_next;
        end
    end

    // A pair may straddle the array end; the pointer arithmetic wraps it naturally
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]  <= '{inst: bus.fetch_inst1, pc: bus.fetch_pc};
            r_mem[w_wr_ptr2] <= '{inst: bus.fetch_inst2, pc: pc_next(bus.fetch_pc)};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign w_rd_idx[gi]   = r_rd_ptr + PW'(gi);
            assign w_lane_vld[gi] = (r_count > CW'(gi));
            assign w_lane_ent[gi] = w_lane_vld[gi] ? r_mem[w_rd_idx[gi]] : '0;
        end
    endgenerate

    assign bus.fetch_ready = w_ready;
    assign bus.out_valid1  = w_lane_vld[0];
    assign bus.out_valid2  = w_lane_vld[1];
    assign bus.out_inst1   = w_lane_ent[0].inst;
    assign bus.out_pc1     = w_lane_ent[0].pc;
    assign bus.out_inst2   = w_lane_ent[1].inst;
    assign bus.out_pc2     = w_lane_ent[1].pc;

`ifdef INST_PAIR_BUF_STATS_EN
    pair_buf_stats u_stats (
        .clk              (clk),
        .reset            (reset),
        .i_clear          (bus.flush),
        .i_stall          (bus.fetch_valid && !w_ready),
        .i_eff            (w_eff),
        .o_full_stall_cnt (full_stall_cnt),
        .o_issue_word_cnt (issue_word_cnt)
    );
`endif

    a_no_issue3: assert property (@(posedge clk) disable iff (!reset) bus.issue_count != 2'd3);
endmodule
